// File: rtl/control_pkg.sv
// Shared definitions for the multi-cycle R-type sequencer: state encoding,
// instruction field codes and ALU operation codes.
package control_pkg;

    typedef enum logic [2:0] {
        INICIO     = 3'd0,
        BUSQUEDA   = 3'd1,
        DECODIFICA = 3'd2,
        EJECUTA    = 3'd3,
        ESCRIBE    = 3'd4,
        ERROR      = 3'd5
    } estado_t;

    localparam logic [5:0] OPCODE_R  = 6'b000000;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam int WAIT_MAX_DEF = 15;
    localparam int CNT_W_DEF    = 16;

    // The block is busy whenever it is working on an instruction.
    function automatic logic es_ocupado(input estado_t e);
        return (e != INICIO) && (e != ERROR);
    endfunction

endpackage

// File: rtl/control_multiciclo_if.sv
// Control/handshake bundle between the sequencer and the datapath/imem.
interface control_multiciclo_if #(
    parameter int CNT_W = 16
);
    logic             habilitar;
    logic [5:0]       OPcode;
    logic [5:0]       funct;
    logic             imem_ack;
    logic             imem_req;
    logic             IRWrite;
    logic             PCWrite;
    logic             RegWrite;
    logic [2:0]       ALUcontrol;
    logic             MemToWrite;
    logic             MemToReg;
    logic             ocupado;
    logic             instr_invalida;
    logic             error_timeout;
    logic [CNT_W-1:0] instr_count;
    logic [2:0]       estado;

    // Sequencer side
    modport master (
        input  habilitar, OPcode, funct, imem_ack,
        output imem_req, IRWrite, PCWrite, RegWrite, ALUcontrol, MemToWrite,
               MemToReg, ocupado, instr_invalida, error_timeout, instr_count,
               estado
    );

    // Datapath / instruction-memory side
    modport slave (
        output habilitar, OPcode, funct, imem_ack,
        input  imem_req, IRWrite, PCWrite, RegWrite, ALUcontrol, MemToWrite,
               MemToReg, ocupado, instr_invalida, error_timeout, instr_count,
               estado
    );
endinterface

// File: rtl/alu_decodificador.sv
// Combinational funct -> ALU operation decoder; valido flags supported codes.
module alu_decodificador
    import control_pkg::*;
(
    input  logic [5:0] funct,
    output logic [2:0] ALUcontrol,
    output logic       valido
);

    // Map each supported funct field onto its ALU operation.
    always_comb begin
        ALUcontrol = ALU_AND;
        valido     = 1'b0;
        case (funct)
            FUNCT_ADD: begin ALUcontrol = ALU_ADD; valido = 1'b1; end
            FUNCT_SUB: begin ALUcontrol = ALU_SUB; valido = 1'b1; end
            FUNCT_AND: begin ALUcontrol = ALU_AND; valido = 1'b1; end
            FUNCT_OR:  begin ALUcontrol = ALU_OR;  valido = 1'b1; end
            FUNCT_SLT: begin ALUcontrol = ALU_SLT; valido = 1'b1; end
            default:   ;
        endcase
    end

endmodule

// File: rtl/control_multiciclo.sv
// Multi-cycle sequencer for R-type instructions: fetch, decode, execute,
// write-back. Unsupported instructions are skipped and flagged; a fetch that
// never gets acknowledged parks the block in ERROR until reset.
module control_multiciclo #(
    parameter logic [5:0] OPCODE_R = control_pkg::OPCODE_R,
    parameter int          WAIT_MAX = control_pkg::WAIT_MAX_DEF,
    parameter int          CNT_W    = control_pkg::CNT_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    control_multiciclo_if.master bus
);
    import control_pkg::*;

    localparam int TW = $clog2(WAIT_MAX + 1);

    estado_t          estado_reg, estado_next;
    logic [5:0]       opcode_reg, funct_reg;
    logic [TW-1:0]    espera_reg;
    logic [CNT_W-1:0] count_reg;
    logic             invalida_reg;
    logic             imem_req_reg, reg_write_reg, mem_to_reg_reg;
    logic             ocupado_reg, error_reg;
    logic [2:0]       alu_reg;

    logic [5:0]       opcode_dec, funct_dec;
    logic [2:0]       alu_op;
    logic             funct_valido, instr_soportada, fetch_ok;

    // While decoding, look at the live IR fields; afterwards the latched copy
    // is used so later IR changes cannot disturb the instruction in flight.
    assign opcode_dec = (estado_reg == DECODIFICA) ? bus.OPcode : opcode_reg;
    assign funct_dec  = (estado_reg == DECODIFICA) ? bus.funct  : funct_reg;

    alu_decodificador u_alu_dec (
        .funct      (funct_dec),
        .ALUcontrol (alu_op),
        .valido     (funct_valido)
    );

    assign instr_soportada = (opcode_dec == OPCODE_R) && funct_valido;
    assign fetch_ok        = (estado_reg == BUSQUEDA) && bus.imem_ack;

    // Next-state selection; the ack in the final wait cycle beats the timeout.
    always_comb begin
        estado_next = INICIO;
        case (estado_reg)
            INICIO:     estado_next = bus.habilitar ? BUSQUEDA : INICIO;
            BUSQUEDA: begin
                if (bus.imem_ack)
                    estado_next = DECODIFICA;
                else if (espera_reg == TW'(WAIT_MAX - 1))
                    estado_next = ERROR;
                else
                    estado_next = BUSQUEDA;
            end
            DECODIFICA: begin
                if (instr_soportada)
                    estado_next = EJECUTA;
                else
                    estado_next = bus.habilitar ? BUSQUEDA : INICIO;
            end
            EJECUTA:    estado_next = ESCRIBE;
            ESCRIBE:    estado_next = bus.habilitar ? BUSQUEDA : INICIO;
            ERROR:      estado_next = ERROR;
            default:    estado_next = INICIO;
        endcase
    end

    // State, bookkeeping and registered Moore outputs for the state being entered.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            estado_reg     <= INICIO;
            opcode_reg     <= '0;
            funct_reg      <= '0;
            espera_reg     <= '0;
            count_reg      <= '0;
            invalida_reg   <= 1'b0;
            imem_req_reg   <= 1'b0;
            reg_write_reg  <= 1'b0;
            mem_to_reg_reg <= 1'b0;
            ocupado_reg    <= 1'b0;
            error_reg      <= 1'b0;
            alu_reg        <= '0;
        end else begin
            estado_reg <= estado_next;

            // Wait counter only runs while a fetch is outstanding.
            if ((estado_reg == BUSQUEDA) && !bus.imem_ack)
                espera_reg <= espera_reg + TW'(1);
            else
                espera_reg <= '0;

            if (estado_reg == DECODIFICA) begin
                opcode_reg <= bus.OPcode;
                funct_reg  <= bus.funct;
                if (!instr_soportada)
                    invalida_reg <= 1'b1;
            end

            if (estado_reg == ESCRIBE)
                count_reg <= count_reg + CNT_W'(1);

            imem_req_reg   <= (estado_next == BUSQUEDA);
            reg_write_reg  <= (estado_next == ESCRIBE);
            mem_to_reg_reg <= (estado_next == ESCRIBE);
            ocupado_reg    <= es_ocupado(estado_next);
            error_reg      <= (estado_next == ERROR);

            if (estado_next == EJECUTA)
                alu_reg <= alu_op;
            else if (estado_next != ESCRIBE)
                alu_reg <= '0;
        end
    end

    assign bus.imem_req       = imem_req_reg;
    assign bus.IRWrite        = fetch_ok;
    assign bus.PCWrite        = fetch_ok;
    assign bus.RegWrite       = reg_write_reg;
    assign bus.ALUcontrol     = alu_reg;
    // Only R-type arithmetic is executed, so data memory is never written.
    assign bus.MemToWrite     = 1'b0;
    assign bus.MemToReg       = mem_to_reg_reg;
    assign bus.ocupado        = ocupado_reg;
    assign bus.instr_invalida = invalida_reg;
    assign bus.error_timeout  = error_reg;
    assign bus.instr_count    = count_reg;
    assign bus.estado         = estado_reg;

endmodule

// File: tb/tb_control_multiciclo.sv
// Directed bench for control_multiciclo: R-type flow, wait states, NOP skip,
// fetch timeout, last-cycle ack, reset and enable drop mid-instruction.
module tb_control_multiciclo;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    control_multiciclo_if #(.CNT_W(16)) bus ();

    control_multiciclo #(
        .OPCODE_R (6'b000000),
        .WAIT_MAX (15),
        .CNT_W    (16)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end else begin
            $display("ok   %s: %0h", tag, obs);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reset, then enable: leaves the DUT in its first BUSQUEDA cycle.
    task automatic start_run();
        rst_n         = 1'b0;
        bus.habilitar = 1'b0;
        bus.imem_ack  = 1'b0;
        tick();
        rst_n         = 1'b1;
        bus.habilitar = 1'b1;
        tick();
        check_val("start_estado", 32'(bus.estado), 32'd1);
    endtask

    // One R-type instruction starting from the first BUSQUEDA cycle.
    task automatic run_r(input string nm, input logic [5:0] f, input int waits,
                         input logic [2:0] exp_alu);
        bus.OPcode   = 6'b000000;
        bus.funct    = f;
        bus.imem_ack = 1'b0;
        for (int i = 0; i < waits; i++) begin
            tick();
            check_val({nm, "_wait"}, 32'(bus.estado), 32'd1);
        end
        bus.imem_ack = 1'b1;
        tick();
        check_val({nm, "_dec"}, 32'(bus.estado), 32'd2);
        bus.imem_ack = 1'b0;
        tick();
        check_val({nm, "_eje"}, 32'(bus.estado), 32'd3);
        check_val({nm, "_eje_alu"}, 32'(bus.ALUcontrol), 32'(exp_alu));
        check_val({nm, "_eje_rw"}, 32'(bus.RegWrite), 32'd0);
        // IR moves on; the latched instruction must not change
        bus.OPcode = 6'b101011;
        bus.funct  = 6'b111111;
        tick();
        check_val({nm, "_esc"}, 32'(bus.estado), 32'd4);
        check_val({nm, "_esc_alu"}, 32'(bus.ALUcontrol), 32'(exp_alu));
        check_val({nm, "_esc_rw"}, 32'(bus.RegWrite), 32'd1);
        check_val({nm, "_esc_m2r"}, 32'(bus.MemToReg), 32'd1);
        check_val({nm, "_esc_mw"}, 32'(bus.MemToWrite), 32'd0);
        tick();
        check_val({nm, "_next"}, 32'(bus.estado), 32'd1);
        check_val({nm, "_next_alu"}, 32'(bus.ALUcontrol), 32'd0);
        check_val({nm, "_next_rw"}, 32'(bus.RegWrite), 32'd0);
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.habilitar = 1'b0;
        bus.OPcode    = 6'b000000;
        bus.funct     = 6'b000000;
        bus.imem_ack  = 1'b0;

        // Reset state
        tick();
        tick();
        check_val("rst_estado", 32'(bus.estado), 32'd0);
        check_val("rst_req", 32'(bus.imem_req), 32'd0);
        check_val("rst_ocupado", 32'(bus.ocupado), 32'd0);
        check_val("rst_count", 32'(bus.instr_count), 32'd0);
        check_val("rst_inv", 32'(bus.instr_invalida), 32'd0);
        check_val("rst_err", 32'(bus.error_timeout), 32'd0);

        // add with ack tied high
        rst_n         = 1'b1;
        bus.habilitar = 1'b1;
        bus.imem_ack  = 1'b1;
        bus.funct     = 6'b100000;
        tick();
        check_val("add_c1_estado", 32'(bus.estado), 32'd1);
        check_val("add_c1_req", 32'(bus.imem_req), 32'd1);
        check_val("add_c1_irw", 32'(bus.IRWrite), 32'd1);
        check_val("add_c1_pcw", 32'(bus.PCWrite), 32'd1);
        check_val("add_c1_ocup", 32'(bus.ocupado), 32'd1);
        tick();
        check_val("add_c2_estado", 32'(bus.estado), 32'd2);
        check_val("add_c2_irw_ignored", 32'(bus.IRWrite), 32'd0);
        check_val("add_c2_rw", 32'(bus.RegWrite), 32'd0);
        check_val("add_c2_alu", 32'(bus.ALUcontrol), 32'd0);
        tick();
        check_val("add_c3_estado", 32'(bus.estado), 32'd3);
        check_val("add_c3_alu", 32'(bus.ALUcontrol), 32'h2);
        check_val("add_c3_rw", 32'(bus.RegWrite), 32'd0);
        tick();
        check_val("add_c4_estado", 32'(bus.estado), 32'd4);
        check_val("add_c4_alu", 32'(bus.ALUcontrol), 32'h2);
        check_val("add_c4_rw", 32'(bus.RegWrite), 32'd1);
        tick();
        check_val("add_c5_estado", 32'(bus.estado), 32'd1);
        check_val("add_count", 32'(bus.instr_count), 32'd1);

        // sub, and, or, slt with 3 wait cycles each
        start_run();
        run_r("sub", 6'b100010, 3, 3'b110);
        run_r("and", 6'b100100, 3, 3'b000);
        run_r("or",  6'b100101, 3, 3'b001);
        run_r("slt", 6'b101010, 3, 3'b111);
        check_val("seq_count", 32'(bus.instr_count), 32'd4);

        // lw is unsupported: skipped as NOP, then add completes
        start_run();
        bus.OPcode   = 6'b100011;
        bus.funct    = 6'b100000;
        bus.imem_ack = 1'b1;
        tick();
        check_val("nop_dec", 32'(bus.estado), 32'd2);
        check_val("nop_inv_before", 32'(bus.instr_invalida), 32'd0);
        bus.imem_ack = 1'b0;
        tick();
        check_val("nop_back", 32'(bus.estado), 32'd1);
        check_val("nop_inv", 32'(bus.instr_invalida), 32'd1);
        check_val("nop_rw", 32'(bus.RegWrite), 32'd0);
        check_val("nop_count", 32'(bus.instr_count), 32'd0);
        run_r("add2", 6'b100000, 0, 3'b010);
        check_val("nop_add_count", 32'(bus.instr_count), 32'd1);
        check_val("nop_inv_sticky", 32'(bus.instr_invalida), 32'd1);

        // Fetch timeout: 15 request cycles then ERROR
        start_run();
        check_val("to_req_c1", 32'(bus.imem_req), 32'd1);
        for (int i = 2; i <= 15; i++) begin
            tick();
            check_val($sformatf("to_req_c%0d", i), 32'(bus.imem_req), 32'd1);
        end
        tick();
        check_val("to_estado", 32'(bus.estado), 32'd5);
        check_val("to_err", 32'(bus.error_timeout), 32'd1);
        check_val("to_req_off", 32'(bus.imem_req), 32'd0);
        check_val("to_ocup", 32'(bus.ocupado), 32'd0);
        for (int i = 0; i < 50; i++) begin
            bus.imem_ack  = 1'($urandom_range(0, 1));
            bus.habilitar = 1'($urandom_range(0, 1));
            tick();
            check_val("to_hold", 32'(bus.estado), 32'd5);
        end
        rst_n = 1'b0;
        tick();
        check_val("to_rst_estado", 32'(bus.estado), 32'd0);
        check_val("to_rst_err", 32'(bus.error_timeout), 32'd0);

        // Ack in the 15th BUSQUEDA cycle wins over the timeout
        start_run();
        bus.OPcode = 6'b000000;
        bus.funct  = 6'b100000;
        for (int i = 2; i <= 15; i++) tick();
        check_val("last_ack_still_busq", 32'(bus.estado), 32'd1);
        bus.imem_ack = 1'b1;
        tick();
        check_val("last_ack_dec", 32'(bus.estado), 32'd2);
        check_val("last_ack_err", 32'(bus.error_timeout), 32'd0);

        // Reset during EJECUTA
        start_run();
        bus.imem_ack = 1'b1;
        tick();
        bus.imem_ack = 1'b0;
        tick();
        check_val("rste_eje", 32'(bus.estado), 32'd3);
        rst_n = 1'b0;
        tick();
        check_val("rste_estado", 32'(bus.estado), 32'd0);
        check_val("rste_rw", 32'(bus.RegWrite), 32'd0);
        check_val("rste_alu", 32'(bus.ALUcontrol), 32'd0);
        check_val("rste_req", 32'(bus.imem_req), 32'd0);
        check_val("rste_ocup", 32'(bus.ocupado), 32'd0);
        check_val("rste_count", 32'(bus.instr_count), 32'd0);

        // habilitar dropped in EJECUTA: finish, then INICIO
        start_run();
        bus.imem_ack = 1'b1;
        tick();
        bus.imem_ack = 1'b0;
        tick();
        check_val("hab_eje", 32'(bus.estado), 32'd3);
        bus.habilitar = 1'b0;
        tick();
        check_val("hab_esc", 32'(bus.estado), 32'd4);
        check_val("hab_esc_rw", 32'(bus.RegWrite), 32'd1);
        tick();
        check_val("hab_inicio", 32'(bus.estado), 32'd0);
        check_val("hab_count", 32'(bus.instr_count), 32'd1);
        check_val("hab_ocup", 32'(bus.ocupado), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/control_multiciclo.md
Name: control_multiciclo

Overview:
Multi-cycle sequencer for the R-type datapath: fetch, decode, execute, write-back. It handshakes with instruction memory and drives register-file and ALU control (RegWrite, ALUcontrol, MemToWrite, MemToReg) plus PC/IR write strobes. Unknown instructions are skipped as NOPs and flagged. A fetch that never completes halts the block until reset.

Parameters:
OPCODE_R, 6'b000000, opcode of R-type instructions
WAIT_MAX, 15, max BUSQUEDA cycles without imem_ack before ERROR (>=1)
CNT_W, 16, width of retired-instruction counter

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  reset, synchronous, active-low
habilitar  in  1  run enable, sampled in INICIO and at end of ESCRIBE
OPcode  in  6  instruction bits [31:26] from IR
funct  in  6  instruction bits [5:0] from IR
imem_ack  in  1  instruction memory data valid
imem_req  out  1  instruction fetch request
IRWrite  out  1  load IR
PCWrite  out  1  PC <= PC+4
RegWrite  out  1  register-file write enable
ALUcontrol  out  3  ALU operation
MemToWrite  out  1  data-memory write enable; always 0 for supported instructions
MemToReg  out  1  write-back mux select; 1 selects ALU result
ocupado  out  1  high in any state except INICIO and ERROR
instr_invalida  out  1  sticky: an unsupported instruction was decoded
error_timeout  out  1  high in ERROR
instr_count  out  CNT_W  retired R-type instructions, wraps modulo 2^CNT_W
estado  out  3  current state, debug

Behaviour:
- States: INICIO=0, BUSQUEDA=1, DECODIFICA=2, EJECUTA=3, ESCRIBE=4, ERROR=5. Codes 6-7 go to INICIO on the next edge.
- Reset (rst_n=0 at an edge), including mid-instruction: state INICIO, all outputs 0, instr_count 0, instr_invalida 0, latched opcode/funct 0, timeout counter 0.
- Outputs are Moore, decoded from state and latched registers only. Exception: IRWrite and PCWrite are BUSQUEDA && imem_ack, combinational.
- INICIO: all strobes 0. If habilitar=1, go to BUSQUEDA.
- BUSQUEDA: imem_req=1.
  - Timeout counter clears on entry and increments each cycle without ack.
  - imem_ack=1: IRWrite=PCWrite=1 that cycle, then DECODIFICA.
  - WAIT_MAX cycles elapsed without ack: go to ERROR.
  - An ack in the last allowed cycle wins over the timeout.
- DECODIFICA: latch OPcode and funct.
  - Supported means OPcode==OPCODE_R and funct is one of: 100000 add->010, 100010 sub->110, 100100 and->000, 100101 or->001, 101010 slt->111.
  - Supported: go to EJECUTA.
  - Otherwise: set instr_invalida; go to BUSQUEDA if habilitar=1, else INICIO. No register write occurs.
- EJECUTA: ALUcontrol = decoded op, all other strobes 0; go to ESCRIBE.
- ESCRIBE: RegWrite=1, MemToReg=1, MemToWrite=0, ALUcontrol held; instr_count+1 at exit. Go to BUSQUEDA if habilitar=1, else INICIO.
- ERROR: imem_req and all strobes 0, error_timeout=1. Exits only via reset.
- Latency: 4 cycles per R-type instruction with zero-wait ack; a NOP takes 2 cycles.
- habilitar falling mid-instruction: the instruction completes, then INICIO.
- imem_ack outside BUSQUEDA is ignored.
- ALUcontrol is 0 outside EJECUTA and ESCRIBE.
- instr_count wraps from all-ones to 0 with no flag.
- OPcode/funct changes after DECODIFICA do not affect the current instruction.

Decomposition:
- Package control_pkg: state enum/encoding, OPCODE_R, funct codes, ALU codes (ALU_ADD=010, ALU_SUB=110, ALU_AND=000, ALU_OR=001, ALU_SLT=111).
- Sub-module alu_decodificador: combinational, funct -> {ALUcontrol, valido}; instantiated once on the latched funct.

Test Plan:
- Reset then habilitar=1, imem_ack tied 1, add (OPcode 0, funct 100000) -> estado 1,2,3,4,1; RegWrite=1 only in cycle 4; ALUcontrol=010 in cycles 3-4; instr_count=1.
- Sequence sub, and, or, slt with ack after 3 wait cycles each -> ALUcontrol 110, 000, 001, 111 in order; each instruction takes 7 cycles; instr_count=4.
- OPcode=6'b100011 (lw), then add -> instr_invalida=1 after the first decode, no RegWrite for it; the following add completes; instr_count=1.
- imem_ack held 0, WAIT_MAX=15 -> imem_req high 15 cycles, then estado=5, error_timeout=1; stays there 50 cycles regardless of imem_ack/habilitar; rst_n=0 returns to INICIO.
- Ack exactly in the 15th BUSQUEDA cycle -> DECODIFICA, not ERROR.
- rst_n=0 during EJECUTA -> next edge estado=0, all outputs 0, no RegWrite pulse. Separately: habilitar dropped in EJECUTA -> ESCRIBE completes, then INICIO.
